// File: rtl/cpu_boot_loader_if.sv
// Host byte stream, CPU bus and memory bus of the 6502 boot loader.
// The loader uses the slave view; the host/bench side uses the master view.
interface cpu_boot_loader_if;
  logic        host_valid;
  logic [7:0]  host_data;
  logic        host_ready;
  logic [15:0] cpu_adr_bus;
  logic [7:0]  cpu_data_out;
  logic        cpu_RW;
  logic        cpu_n_reset;
  logic [15:0] mem_adr;
  logic [7:0]  mem_data_out;
  logic        mem_RW;
  logic        running;
  logic        err;
  logic [15:0] load_count;

  modport master (
    output host_valid, host_data, cpu_adr_bus, cpu_data_out, cpu_RW,
    input  host_ready, cpu_n_reset, mem_adr, mem_data_out, mem_RW,
           running, err, load_count
  );

  modport slave (
    input  host_valid, host_data, cpu_adr_bus, cpu_data_out, cpu_RW,
    output host_ready, cpu_n_reset, mem_adr, mem_data_out, mem_RW,
           running, err, load_count
  );
endinterface

// File: rtl/cpu_boot_loader.sv
// Boot loader for the 6502 core: holds the CPU in reset, parses host
// commands (L = load, R = run, H = halt), writes program bytes into memory
// and owns the memory-bus mux between loader and CPU.
module cpu_boot_loader #(
  parameter int RESET_CYCLES = 4,
  parameter int AUTO_RUN     = 0
) (
  input logic         clk,
  input logic         reset,
  cpu_boot_loader_if.slave bus
);

  localparam logic [2:0] CMD  = 3'd0;
  localparam logic [2:0] AH   = 3'd1;
  localparam logic [2:0] AL   = 3'd2;
  localparam logic [2:0] LH   = 3'd3;
  localparam logic [2:0] LL   = 3'd4;
  localparam logic [2:0] DATA = 3'd5;
  localparam logic [2:0] WR   = 3'd6;

  localparam logic [7:0] RESET_LIMIT = 8'(RESET_CYCLES);

  logic [2:0]  state_q, state_d;
  logic        run_q, run_d;
  logic        err_q, err_d;
  logic        started_q;
  logic [15:0] curAdr_q, curAdr_d;
  logic [15:0] remain_q, remain_d;
  logic [15:0] loadCount_q, loadCount_d;
  logic [15:0] memAdr_q, memAdr_d;
  logic [7:0]  memData_q, memData_d;
  logic        memRW_q, memRW_d;
  logic [7:0]  haltCnt_q, haltCnt_d;
  logic        nReset_q, nReset_d;

  logic        hostReady;
  logic        hostAccept;
  logic [7:0]  haltCntSat;

  // The first cycle after reset refuses host bytes, as does the write cycle.
  assign hostReady  = started_q && (state_q != WR);
  assign hostAccept = bus.host_valid && hostReady;
  assign haltCntSat = (haltCnt_q == RESET_LIMIT) ? haltCnt_q : haltCnt_q + 8'd1;

  // Command parser and loader write sequencing.
  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    err_d       = err_q;
    curAdr_d    = curAdr_q;
    remain_d    = remain_q;
    loadCount_d = loadCount_q;
    memAdr_d    = memAdr_q;
    memData_d   = memData_q;
    memRW_d     = memRW_q;
    case (state_q)
      CMD: begin
        if (hostAccept) begin
          case (bus.host_data)
            8'h4C: begin
              run_d   = 1'b0;
              state_d = AH;
            end
            8'h52:   run_d = 1'b1;
            8'h48:   run_d = 1'b0;
            default: err_d = 1'b1;
          endcase
        end
      end
      AH: begin
        if (hostAccept) begin
          curAdr_d = {bus.host_data, curAdr_q[7:0]};
          state_d  = AL;
        end
      end
      AL: begin
        if (hostAccept) begin
          curAdr_d = {curAdr_q[15:8], bus.host_data};
          state_d  = LH;
        end
      end
      LH: begin
        if (hostAccept) begin
          remain_d = {bus.host_data, remain_q[7:0]};
          state_d  = LL;
        end
      end
      LL: begin
        if (hostAccept) begin
          remain_d    = {remain_q[15:8], bus.host_data};
          loadCount_d = 16'd0;
          state_d     = ({remain_q[15:8], bus.host_data} == 16'd0) ? CMD : DATA;
        end
      end
      DATA: begin
        if (hostAccept) begin
          memData_d = bus.host_data;
          memAdr_d  = curAdr_q;
          memRW_d   = 1'b0;
          state_d   = WR;
        end
      end
      WR: begin
        memRW_d     = 1'b1;
        curAdr_d    = curAdr_q + 16'd1;
        remain_d    = remain_q - 16'd1;
        loadCount_d = loadCount_q + 16'd1;
        state_d     = (remain_q == 16'd1) ? CMD : DATA;
      end
      default: state_d = CMD;
    endcase
  end

  // Halt counter: keeps the CPU in reset for RESET_CYCLES before any release.
  always_comb begin
    haltCnt_d = haltCnt_q;
    nReset_d  = nReset_q;
    if (!run_q) begin
      nReset_d  = 1'b0;
      haltCnt_d = nReset_q ? 8'd0 : haltCntSat;
    end else if (!nReset_q) begin
      haltCnt_d = haltCntSat;
      nReset_d  = (haltCnt_q == RESET_LIMIT);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= CMD;
      run_q       <= (AUTO_RUN != 0);
      err_q       <= 1'b0;
      started_q   <= 1'b0;
      curAdr_q    <= 16'd0;
      remain_q    <= 16'd0;
      loadCount_q <= 16'd0;
      memAdr_q    <= 16'd0;
      memData_q   <= 8'd0;
      memRW_q     <= 1'b1;
      haltCnt_q   <= 8'd0;
      nReset_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      err_q       <= err_d;
      started_q   <= 1'b1;
      curAdr_q    <= curAdr_d;
      remain_q    <= remain_d;
      loadCount_q <= loadCount_d;
      memAdr_q    <= memAdr_d;
      memData_q   <= memData_d;
      memRW_q     <= memRW_d;
      haltCnt_q   <= haltCnt_d;
      nReset_q    <= nReset_d;
    end
  end

  assign bus.host_ready   = hostReady;
  assign bus.cpu_n_reset  = nReset_q;
  assign bus.running      = nReset_q;
  assign bus.err          = err_q;
  assign bus.load_count   = loadCount_q;
  assign bus.mem_adr      = nReset_q ? bus.cpu_adr_bus  : memAdr_q;
  assign bus.mem_data_out = nReset_q ? bus.cpu_data_out : memData_q;
  assign bus.mem_RW       = nReset_q ? bus.cpu_RW       : memRW_q;

endmodule

// File: tb/tb_cpu_boot_loader.sv
// Self-checking bench for cpu_boot_loader: randomized loads checked against
// an address/data list computed from the command bytes, plus run/halt timing.
module tb_cpu_boot_loader;

  localparam int RC = 4;

  logic clk = 1'b0;
  logic reset;
  logic resetA;

  cpu_boot_loader_if bus();
  cpu_boot_loader_if busA();

  cpu_boot_loader #(.RESET_CYCLES(RC), .AUTO_RUN(0)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  cpu_boot_loader #(.RESET_CYCLES(RC), .AUTO_RUN(1)) dutA (
    .clk(clk), .reset(resetA), .bus(busA.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [15:0] wrAdr[$];
  logic [7:0]  wrData[$];
  logic [15:0] expAdr[$];
  logic [7:0]  expData[$];
  logic [7:0]  dataBuf[0:15];

  // Record every loader-driven memory write cycle (one sample per cycle).
  always @(negedge clk) begin
    if (bus.mem_RW === 1'b0 && bus.running === 1'b0) begin
      wrAdr.push_back(bus.mem_adr);
      wrData.push_back(bus.mem_data_out);
    end
  end

  // Present one byte and hold it until the loader accepts it.
  task automatic sendByte(input logic [7:0] b);
    int waitCycles;
    @(negedge clk);
    bus.host_valid = 1'b1;
    bus.host_data  = b;
    waitCycles = 0;
    while (bus.host_ready !== 1'b1 && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    if (bus.host_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("[TB] FAIL send_timeout byte=%02h host_ready=%b required=1", b, bus.host_ready);
      bus.host_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      bus.host_valid = 1'b0;
    end
  endtask

  // Send a full 'L' command using dataBuf as payload; append the expected writes.
  task automatic applyLoad(input logic [15:0] start, input int len);
    logic [15:0] lenVec;
    lenVec = 16'(len);
    sendByte(8'h4C);
    sendByte(start[15:8]);
    sendByte(start[7:0]);
    sendByte(lenVec[15:8]);
    sendByte(lenVec[7:0]);
    for (int i = 0; i < len; i++) begin
      sendByte(dataBuf[i]);
      expAdr.push_back(start + 16'(i));
      expData.push_back(dataBuf[i]);
    end
  endtask

  task automatic clearQueues();
    wrAdr.delete();
    wrData.delete();
    expAdr.delete();
    expData.delete();
  endtask

  task automatic test_reset();
    logic bad;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.cpu_n_reset !== 1'b0 || bus.running !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_run n_reset=%b running=%b required=0", bus.cpu_n_reset, bus.running);
    end
    checks++;
    if (bus.host_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_ready got=%b required=0", bus.host_ready);
    end
    checks++;
    if (bus.mem_RW !== 1'b1 || bus.mem_adr !== 16'h0000 || bus.mem_data_out !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_bus RW=%b adr=%04h data=%02h required 1/0000/00",
               bus.mem_RW, bus.mem_adr, bus.mem_data_out);
    end
    checks++;
    if (bus.err !== 1'b0 || bus.load_count !== 16'd0) begin
      failures++;
      $display("[TB] FAIL reset_status err=%b load_count=%0d required 0/0", bus.err, bus.load_count);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.host_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ready_second_cycle got=%b required=1", bus.host_ready);
    end
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.running !== 1'b0 || bus.mem_RW !== 1'b1 || bus.err !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("[TB] FAIL hold_halted running=%b RW=%b err=%b required 0/1/0",
               bus.running, bus.mem_RW, bus.err);
    end
  endtask

  task automatic test_load_basic();
    clearQueues();
    dataBuf[0] = 8'hA9;
    dataBuf[1] = 8'h05;
    dataBuf[2] = 8'hAA;
    applyLoad(16'h8000, 3);
    repeat (3) @(negedge clk);
    checks++;
    if (wrAdr.size() != expAdr.size()) begin
      failures++;
      $display("[TB] FAIL basic_write_count got=%0d required=%0d", wrAdr.size(), expAdr.size());
    end else begin
      for (int i = 0; i < expAdr.size(); i++) begin
        checks++;
        if (wrAdr[i] !== expAdr[i] || wrData[i] !== expData[i]) begin
          failures++;
          $display("[TB] FAIL basic_write%0d got=%02h@%04h required=%02h@%04h",
                   i, wrData[i], wrAdr[i], expData[i], expAdr[i]);
        end
      end
    end
    checks++;
    if (bus.load_count !== 16'd3) begin
      failures++;
      $display("[TB] FAIL basic_load_count got=%0d required=3", bus.load_count);
    end
    checks++;
    if (bus.running !== 1'b0 || bus.host_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL basic_idle running=%b ready=%b required 0/1", bus.running, bus.host_ready);
    end
  endtask

  task automatic test_load_wrap();
    clearQueues();
    for (int i = 0; i < 4; i++) dataBuf[i] = 8'($urandom);
    applyLoad(16'hFFFE, 4);
    repeat (3) @(negedge clk);
    checks++;
    if (wrAdr.size() != 4) begin
      failures++;
      $display("[TB] FAIL wrap_write_count got=%0d required=4", wrAdr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wrAdr[i] !== expAdr[i] || wrData[i] !== expData[i]) begin
          failures++;
          $display("[TB] FAIL wrap_write%0d got=%02h@%04h required=%02h@%04h",
                   i, wrData[i], wrAdr[i], expData[i], expAdr[i]);
        end
      end
    end
    checks++;
    if (bus.load_count !== 16'd4) begin
      failures++;
      $display("[TB] FAIL wrap_load_count got=%0d required=4", bus.load_count);
    end
  endtask

  task automatic test_back_to_back();
    int lenA;
    int lenB;
    logic [15:0] startA;
    logic [15:0] startB;
    clearQueues();
    lenA   = $urandom_range(1, 6);
    lenB   = $urandom_range(1, 6);
    startA = 16'($urandom);
    startB = 16'($urandom);
    for (int i = 0; i < 16; i++) dataBuf[i] = 8'($urandom);
    applyLoad(startA, lenA);
    for (int i = 0; i < 16; i++) dataBuf[i] = 8'($urandom);
    applyLoad(startB, lenB);
    repeat (3) @(negedge clk);
    checks++;
    if (wrAdr.size() != expAdr.size()) begin
      failures++;
      $display("[TB] FAIL b2b_write_count got=%0d required=%0d", wrAdr.size(), expAdr.size());
    end else begin
      for (int i = 0; i < expAdr.size(); i++) begin
        checks++;
        if (wrAdr[i] !== expAdr[i] || wrData[i] !== expData[i]) begin
          failures++;
          $display("[TB] FAIL b2b_write%0d got=%02h@%04h required=%02h@%04h",
                   i, wrData[i], wrAdr[i], expData[i], expAdr[i]);
        end
      end
    end
    checks++;
    if (bus.load_count !== 16'(lenB)) begin
      failures++;
      $display("[TB] FAIL b2b_load_count got=%0d required=%0d", bus.load_count, lenB);
    end
  endtask

  task automatic test_run();
    int n;
    logic [15:0] a;
    logic [7:0]  d;
    logic        rw;
    sendByte(8'h52);
    n = 0;
    while (bus.running !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n != 1 || bus.cpu_n_reset !== 1'b1) begin
      failures++;
      $display("[TB] FAIL run_latency got=%0d n_reset=%b required=1 cycle", n, bus.cpu_n_reset);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a  = 16'($urandom);
      d  = 8'($urandom);
      rw = 1'($urandom);
      bus.cpu_adr_bus  = a;
      bus.cpu_data_out = d;
      bus.cpu_RW       = rw;
      #1;
      checks++;
      if (bus.mem_adr !== a || bus.mem_data_out !== d || bus.mem_RW !== rw) begin
        failures++;
        $display("[TB] FAIL mux%0d got=%04h/%02h/%b required=%04h/%02h/%b",
                 i, bus.mem_adr, bus.mem_data_out, bus.mem_RW, a, d, rw);
      end
    end
    @(negedge clk);
    bus.cpu_RW = 1'b1;
    sendByte(8'h52);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.running !== 1'b1) begin
      failures++;
      $display("[TB] FAIL run_again got=%b required=1", bus.running);
    end
  endtask

  task automatic test_load_while_running();
    clearQueues();
    sendByte(8'h4C);
    checks++;
    if (bus.running !== 1'b1) begin
      failures++;
      $display("[TB] FAIL l_accept_edge running=%b required=1", bus.running);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.running !== 1'b0) begin
      failures++;
      $display("[TB] FAIL l_next_edge running=%b required=0", bus.running);
    end
    sendByte(8'h90);
    sendByte(8'h00);
    sendByte(8'h00);
    sendByte(8'h01);
    sendByte(8'hEE);
    repeat (3) @(negedge clk);
    checks++;
    if (wrAdr.size() != 1 || wrAdr[0] !== 16'h9000 || wrData[0] !== 8'hEE) begin
      failures++;
      $display("[TB] FAIL running_load count=%0d got=%02h@%04h required=1 EE@9000",
               wrAdr.size(), (wrData.size() > 0) ? wrData[0] : 8'h00,
               (wrAdr.size() > 0) ? wrAdr[0] : 16'h0000);
    end
    sendByte(8'h48);
    sendByte(8'h7F);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.running !== 1'b0 || bus.err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL halt_err running=%b err=%b required 0/1", bus.running, bus.err);
    end
  endtask

  task automatic test_zero_len();
    clearQueues();
    applyLoad(16'h8000, 0);
    repeat (4) @(negedge clk);
    checks++;
    if (wrAdr.size() != 0 || bus.load_count !== 16'd0) begin
      failures++;
      $display("[TB] FAIL zero_len writes=%0d load_count=%0d required 0/0", wrAdr.size(), bus.load_count);
    end
    checks++;
    if (bus.err !== 1'b1 || bus.host_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL err_sticky err=%b ready=%b required 1/1", bus.err, bus.host_ready);
    end
  endtask

  task automatic test_reset_mid_load();
    int n;
    clearQueues();
    sendByte(8'h4C);
    sendByte(8'h80);
    sendByte(8'h00);
    sendByte(8'h00);
    sendByte(8'h05);
    sendByte(8'h3C);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.mem_RW !== 1'b1 || bus.err !== 1'b0 || bus.load_count !== 16'd0) begin
      failures++;
      $display("[TB] FAIL mid_reset RW=%b err=%b load_count=%0d required 1/0/0",
               bus.mem_RW, bus.err, bus.load_count);
    end
    reset = 1'b0;
    repeat (10) @(negedge clk);
    sendByte(8'h52);
    n = 0;
    while (bus.running !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n != 1) begin
      failures++;
      $display("[TB] FAIL post_reset_cmd run_latency=%0d required=1", n);
    end
    checks++;
    if (wrAdr.size() != 1 || wrData[0] !== 8'h3C) begin
      failures++;
      $display("[TB] FAIL mid_reset_writes count=%0d required=1 (3C@8000)", wrAdr.size());
    end
  endtask

  task automatic test_auto_run();
    int n;
    @(negedge clk);
    resetA = 1'b0;
    n = 0;
    while (busA.running !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n != RC + 1) begin
      failures++;
      $display("[TB] FAIL auto_run edges=%0d required=%0d", n, RC + 1);
    end
    checks++;
    if (busA.err !== 1'b0 || busA.cpu_n_reset !== 1'b1) begin
      failures++;
      $display("[TB] FAIL auto_run_status err=%b n_reset=%b required 0/1", busA.err, busA.cpu_n_reset);
    end
  endtask

  // Main sequence.
  initial begin
    reset             = 1'b1;
    resetA            = 1'b1;
    bus.host_valid    = 1'b0;
    bus.host_data     = 8'h00;
    bus.cpu_adr_bus   = 16'h0000;
    bus.cpu_data_out  = 8'h00;
    bus.cpu_RW        = 1'b1;
    busA.host_valid   = 1'b0;
    busA.host_data    = 8'h00;
    busA.cpu_adr_bus  = 16'h0000;
    busA.cpu_data_out = 8'h00;
    busA.cpu_RW       = 1'b1;
    test_reset();
    test_load_basic();
    test_load_wrap();
    test_back_to_back();
    test_run();
    test_load_while_running();
    test_zero_len();
    test_reset_mid_load();
    test_auto_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
